// File: rtl/qspi_arb.sv
// qspi_arb: arbitrates icache and dcache line transfers onto the single QSPI port.
// One owner at a time; its tag, device select and direction are latched for the whole
// transfer. A starvation counter bounds consecutive dcache wins while icache waits.
module qspi_arb #(
  parameter int unsigned PA          = 24,
  parameter int unsigned LINE_LENGTH = 4,
  parameter int unsigned STARVE      = 3,
  localparam int unsigned TW         = PA - $clog2(LINE_LENGTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_req,
  input  logic [TW-1:0] i_tag,
  input  logic [1:0]    i_mem,
  output logic          i_ack,
  input  logic          d_req,
  input  logic          d_write,
  input  logic [TW-1:0] d_tag,
  input  logic [1:0]    d_mem,
  output logic          d_ack,
  output logic          q_req,
  output logic          q_i_d,
  output logic          q_write,
  output logic [TW-1:0] q_paddr,
  output logic [1:0]    q_mem,
  input  logic          q_done,
  output logic          busy
);

  localparam int unsigned CntW = $clog2(STARVE + 1);
  localparam logic [CntW-1:0] CntMax = CntW'(STARVE);

  typedef enum logic [2:0] {
    StIdle,
    StGrantI,
    StGrantD,
    StDoneI,
    StDoneD
  } state_e;

  state_e          state;
  logic [CntW-1:0] starve_cnt;

  // Arbitration, transfer sequencing and latching of the winner's attributes.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= StIdle;
      starve_cnt <= '0;
      q_i_d      <= 1'b0;
      q_write    <= 1'b0;
      q_paddr    <= '0;
      q_mem      <= 2'b00;
    end else begin
      unique case (state)
        StIdle: begin
          // dcache wins ties until it has starved icache for STARVE grants in a row.
          if (d_req && (!i_req || (starve_cnt != CntMax))) begin
            state   <= StGrantD;
            q_i_d   <= 1'b0;
            q_write <= d_write;
            q_paddr <= d_tag;
            q_mem   <= d_mem;
            if (i_req) begin
              starve_cnt <= (starve_cnt == CntMax) ? CntMax : starve_cnt + 1'b1;
            end else begin
              starve_cnt <= '0;
            end
          end else if (i_req) begin
            state      <= StGrantI;
            q_i_d      <= 1'b1;
            q_write    <= 1'b0;
            q_paddr    <= i_tag;
            q_mem      <= i_mem;
            starve_cnt <= '0;
          end
        end
        StGrantI: if (q_done) state <= StDoneI;
        StGrantD: if (q_done) state <= StDoneD;
        StDoneI,
        StDoneD:  state <= StIdle;
        default:  state <= StIdle;
      endcase
    end
  end

  // Handshake outputs are pure state decodes, so no input reaches an output combinationally.
  always_comb begin
    q_req = (state == StGrantI) || (state == StGrantD);
    i_ack = (state == StDoneI);
    d_ack = (state == StDoneD);
    busy  = (state != StIdle);
  end

endmodule

// File: tb/tb_qspi_arb.sv
// tb_qspi_arb: scoreboard bench for qspi_arb. Expected grants are queued as requests are
// raised and popped when the arbiter presents a transfer to the qspi side.
module tb_qspi_arb;

  localparam int unsigned PA = 24;
  localparam int unsigned LINE_LENGTH = 4;
  localparam int unsigned STARVE = 3;
  localparam int unsigned TW = PA - $clog2(LINE_LENGTH);

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, d_req, d_write, q_done;
  logic [TW-1:0] i_tag, d_tag;
  logic [1:0]    i_mem, d_mem;
  logic          i_ack, d_ack, q_req, q_i_d, q_write, busy;
  logic [TW-1:0] q_paddr;
  logic [1:0]    q_mem;

  typedef struct packed {
    logic          i_d;
    logic          write;
    logic [TW-1:0] paddr;
    logic [1:0]    mem;
    logic [1:0]    cnt;
  } txn_t;

  txn_t exp_q[$];
  int   total = 0;
  int   bad = 0;

  qspi_arb #(.PA(PA), .LINE_LENGTH(LINE_LENGTH), .STARVE(STARVE)) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_tag   (i_tag),
    .i_mem   (i_mem),
    .i_ack   (i_ack),
    .d_req   (d_req),
    .d_write (d_write),
    .d_tag   (d_tag),
    .d_mem   (d_mem),
    .d_ack   (d_ack),
    .q_req   (q_req),
    .q_i_d   (q_i_d),
    .q_write (q_write),
    .q_paddr (q_paddr),
    .q_mem   (q_mem),
    .q_done  (q_done),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=0x%0h want=0x%0h at %0t", tag, got, want, $time);
    end
  endtask

  // Returns the number of extra negedges waited before q_req appeared, or -1 on timeout.
  task automatic wait_grant(output int n);
    n = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (q_req === 1'b1) begin
        n = k;
        return;
      end
    end
  endtask

  task automatic serve_start(output txn_t e, output int n);
    e = '0;
    wait_grant(n);
    if (n < 0) begin
      check_eq("grant_timeout", 32'd0, 32'd1);
      return;
    end
    if (exp_q.size() == 0) begin
      check_eq("sb_empty", 32'd0, 32'd1);
      return;
    end
    e = exp_q.pop_front();
    check_eq("grant_i_d",   {31'd0, q_i_d},   {31'd0, e.i_d});
    check_eq("grant_write", {31'd0, q_write}, {31'd0, e.write});
    check_eq("grant_paddr", 32'(q_paddr),     32'(e.paddr));
    check_eq("grant_mem",   32'(q_mem),       32'(e.mem));
    check_eq("starve_cnt",  32'(dut.starve_cnt), 32'(e.cnt));
    check_eq("grant_busy",  {31'd0, busy},    32'd1);
  endtask

  // Holds the transfer for a while, completes it and checks the ack and the idle gap.
  task automatic serve_finish(input txn_t e, input int hold, input bit drop, input bit extra);
    repeat (hold) begin
      @(negedge clk);
      check_eq("hold_req",   {31'd0, q_req}, 32'd1);
      check_eq("hold_paddr", 32'(q_paddr),   32'(e.paddr));
      check_eq("hold_mem",   32'(q_mem),     32'(e.mem));
      check_eq("hold_noack", {30'd0, i_ack, d_ack}, 32'd0);
    end
    @(posedge clk); #1 q_done = 1'b1;
    @(posedge clk); #1 q_done = extra;
    if (drop) begin
      if (e.i_d) i_req = 1'b0;
      else d_req = 1'b0;
    end
    @(negedge clk);
    check_eq("done_i_ack", {31'd0, i_ack}, {31'd0, e.i_d});
    check_eq("done_d_ack", {31'd0, d_ack}, {31'd0, ~e.i_d});
    check_eq("done_q_req", {31'd0, q_req}, 32'd0);
    @(posedge clk); #1 q_done = 1'b0;
    @(negedge clk);
    check_eq("idle_ack",  {30'd0, i_ack, d_ack}, 32'd0);
    check_eq("idle_q_req", {31'd0, q_req}, 32'd0);
    check_eq("idle_busy", {31'd0, busy}, 32'd0);
  endtask

  task automatic push(input logic i_d, input logic w, input logic [TW-1:0] a,
                      input logic [1:0] m, input logic [1:0] c);
    txn_t t;
    t.i_d = i_d; t.write = w; t.paddr = a; t.mem = m; t.cnt = c;
    exp_q.push_back(t);
  endtask

  initial begin
    txn_t e;
    int   n;
    reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; q_done = 1'b0;
    i_tag = '0; d_tag = '0; i_mem = 2'b00; d_mem = 2'b00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_q_req", {31'd0, q_req}, 32'd0);
    check_eq("rst_acks",  {30'd0, i_ack, d_ack}, 32'd0);
    check_eq("rst_busy",  {31'd0, busy}, 32'd0);
    check_eq("rst_attrs", {q_i_d, q_write, q_mem, 6'd0, q_paddr}, 32'd0);
    check_eq("rst_cnt",   32'(dut.starve_cnt), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Single icache fill.
    i_req = 1'b1; i_tag = 22'h12345; i_mem = 2'd1;
    push(1'b1, 1'b0, 22'h12345, 2'd1, 2'd0);
    serve_start(e, n);
    check_eq("fill_latency", 32'(n), 32'd1);
    serve_finish(e, 8, 1'b1, 1'b0);

    // Simultaneous requests: dcache first, icache after exactly a two-cycle gap.
    @(posedge clk); #1;
    i_req = 1'b1; i_tag = 22'h00333; i_mem = 2'd0;
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h00AA0; d_mem = 2'd3;
    push(1'b0, 1'b1, 22'h00AA0, 2'd3, 2'd1);
    push(1'b1, 1'b0, 22'h00333, 2'd0, 2'd0);
    serve_start(e, n);
    serve_finish(e, 2, 1'b1, 1'b0);
    serve_start(e, n);
    check_eq("gap_regrant", 32'(n), 32'd0);
    serve_finish(e, 2, 1'b1, 1'b0);

    // Starvation: dcache re-requests continuously while icache waits.
    @(posedge clk); #1;
    i_req = 1'b1; i_tag = 22'h3FFFFF; i_mem = 2'd2;
    d_req = 1'b1; d_write = 1'b0; d_tag = 22'h01234; d_mem = 2'd1;
    push(1'b0, 1'b0, 22'h01234, 2'd1, 2'd1);
    push(1'b0, 1'b0, 22'h01234, 2'd1, 2'd2);
    push(1'b0, 1'b0, 22'h01234, 2'd1, 2'd3);
    push(1'b1, 1'b0, 22'h3FFFFF, 2'd2, 2'd0);
    push(1'b0, 1'b0, 22'h01234, 2'd1, 2'd1);
    push(1'b1, 1'b0, 22'h3FFFFF, 2'd2, 2'd0);
    for (int k = 0; k < 4; k++) begin
      serve_start(e, n);
      serve_finish(e, 1, 1'b0, 1'b0);
    end
    serve_start(e, n);
    serve_finish(e, 1, 1'b1, 1'b0);
    serve_start(e, n);
    serve_finish(e, 1, 1'b1, 1'b0);

    // Tag stability: requester inputs wiggle during GRANT_D.
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b0; d_tag = 22'h2BEEF; d_mem = 2'd2;
    push(1'b0, 1'b0, 22'h2BEEF, 2'd2, 2'd0);
    serve_start(e, n);
    @(posedge clk); #1;
    d_req = 1'b0; d_tag = 22'h15555; d_mem = 2'd1; d_write = 1'b1;
    serve_finish(e, 3, 1'b1, 1'b0);

    // Reset in the third GRANT_D cycle, then a stray q_done.
    @(posedge clk); #1;
    d_req = 1'b1; d_write = 1'b1; d_tag = 22'h00F0F; d_mem = 2'd0;
    push(1'b0, 1'b1, 22'h00F0F, 2'd0, 2'd0);
    serve_start(e, n);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1; d_req = 1'b0;
    @(posedge clk); #1;
    reset = 1'b0; q_done = 1'b1;
    @(negedge clk);
    check_eq("rstmid_q_req", {31'd0, q_req}, 32'd0);
    check_eq("rstmid_busy",  {31'd0, busy}, 32'd0);
    check_eq("rstmid_acks",  {30'd0, i_ack, d_ack}, 32'd0);
    @(posedge clk); #1 q_done = 1'b0;
    @(negedge clk);
    check_eq("rstmid_done_busy", {31'd0, busy}, 32'd0);
    check_eq("rstmid_done_acks", {30'd0, i_ack, d_ack}, 32'd0);

    // Spurious q_done in IDLE, then held into DONE_I.
    @(posedge clk); #1 q_done = 1'b1;
    @(posedge clk); #1 q_done = 1'b0;
    @(negedge clk);
    check_eq("spur_idle_busy", {31'd0, busy}, 32'd0);
    check_eq("spur_idle_acks", {30'd0, i_ack, d_ack}, 32'd0);
    @(posedge clk); #1;
    i_req = 1'b1; i_tag = 22'h0ABCD; i_mem = 2'd3;
    push(1'b1, 1'b0, 22'h0ABCD, 2'd3, 2'd0);
    serve_start(e, n);
    serve_finish(e, 1, 1'b1, 1'b1);
    @(negedge clk);
    check_eq("spur_after_busy", {31'd0, busy}, 32'd0);
    check_eq("spur_after_acks", {30'd0, i_ack, d_ack}, 32'd0);

    check_eq("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_arb.md
Name: qspi_arb

Overview:
- Arbiter and sequencer for the single shared QSPI line-transfer port.
- Requesters: icache line fill (pull) and dcache line write-back (push) or fill (pull).
- Grants one requester at a time and latches its tag, chip select and direction for the whole transaction.
- Waits for the qspi controller's completion pulse, then acks the owner; a starvation limit stops continuous dcache traffic from locking out instruction fetch.

Parameters:
PA, 24, physical address width
LINE_LENGTH, 4, cache line length in bytes; TW = PA - clog2(LINE_LENGTH) is the tag width
STARVE, 3, max consecutive dcache grants while i_req is pending (>=1)

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_req  in  1  icache line-pull request, level, held until i_ack
i_tag  in  TW  icache line address
i_mem  in  2  target device select for icache transfer
i_ack  out  1  one-cycle pulse: icache transfer complete
d_req  in  1  dcache line request, level, held until d_ack
d_write  in  1  1 = push (write-back), 0 = pull
d_tag  in  TW  dcache line address
d_mem  in  2  target device select for dcache transfer
d_ack  out  1  one-cycle pulse: dcache transfer complete
q_req  out  1  transfer request to qspi controller
q_i_d  out  1  1 = current transfer is icache
q_write  out  1  1 = current transfer is a push
q_paddr  out  TW  latched line address
q_mem  out  2  latched device select
q_done  in  1  one-cycle pulse from qspi: transfer finished
busy  out  1  high in any state except IDLE

Behaviour:
- Reset value for all outputs, state and counter is 0, with state = IDLE.
- Reset wins over every other event, including reset mid-transfer:
  - The next cycle has q_req=0 and no ack.
  - The aborted transfer is never acked.
- States are IDLE, GRANT_I, GRANT_D, DONE_I and DONE_D.
- IDLE:
  - Arbitration is evaluated on the current cycle's requests.
  - Neither request: stay in IDLE.
  - Only one request: grant it.
  - Both requests: grant d, unless starve_cnt == STARVE, in which case grant i.
  - On grant, register q_paddr, q_mem, q_write and q_i_d from the winner. For i, q_write=0 and q_i_d=1.
  - Next state is GRANT_I or GRANT_D.
- GRANT_x:
  - q_req=1; q_paddr, q_mem, q_write and q_i_d stay constant.
  - Requester input changes are ignored, including a deassert of the owner's req. A transfer cannot be aborted.
  - q_done=1 moves to DONE_x.
- DONE_x:
  - q_req=0 and x_ack=1, decoded from state for exactly one cycle.
  - Always returns to IDLE next cycle.
  - The requester drops or re-raises req at the edge after ack, so IDLE never sees a stale req.
- Latency:
  - req high at edge N gives q_req high in cycle N+1.
  - q_done at edge M gives ack in cycle M+1.
  - The next grant is at earliest M+2, so q_req is low for at least 2 cycles between transfers. This gap is the qspi CS-deassert time.
- starve_cnt (width clog2(STARVE+1)):
  - Increments on a d grant made while i_req=1, saturating at STARVE.
  - Clears on any i grant.
  - Clears on a d grant made while i_req=0.
- A dcache miss with a dirty victim is push then pull: two separate d requests. The icache may be granted between them if the starve limit is hit; the dcache tolerates this.
- q_done outside GRANT_x (IDLE, DONE_x) is ignored, with no state change or ack.
- busy = (state != IDLE).
- i_ack and d_ack are never high together. Exactly one ack is given per completed grant.
- Outputs are registered or state-decoded; there are no combinational paths from inputs to outputs.

Test Plan:
- Single fill:
  - Stimulus: i_req=1, i_tag=0x12345, i_mem=1 at edge 0; q_done pulsed in cycle 10.
  - Response: q_req=1, q_i_d=1, q_write=0 and q_paddr=0x12345 from cycle 1; i_ack=1 in cycle 11 only; busy low from cycle 12.
- Simultaneous requests:
  - Stimulus: i_req and d_req (d_write=1, d_tag=0x00AA0) both rise at edge 0.
  - Response: d is granted first with q_write=1 and q_paddr=0x00AA0; after d_ack, i is granted with q_req low for 2 cycles between.
- Starvation (STARVE=3):
  - Stimulus: d_req re-raised immediately after every ack while i_req is held.
  - Response: grant order is d, d, d, i, d, with starve_cnt going 1, 2, 3, 0.
- Tag stability:
  - Stimulus: change d_tag and d_mem, and drop d_req, during GRANT_D.
  - Response: q_paddr and q_mem keep their latched values; d_ack still pulses after q_done.
- Reset mid-transfer:
  - Stimulus: assert reset in cycle 3 of GRANT_D, then send q_done the next cycle.
  - Response: the next cycle has q_req=0, busy=0 and no ack; q_done is ignored.
- Spurious q_done:
  - Stimulus: q_done pulsed in IDLE and in DONE_I.
  - Response: no ack and no state change.
